// File: rtl/stream_byteswap_pkg.sv
// Shared types, CSR map and the unit-swap helper for the stream byte-order converter.
package stream_byteswap_pkg;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } swap_mode_e;

  localparam logic [1:0] ADDR_CTRL     = 2'd0;
  localparam logic [1:0] ADDR_PKT_CNT  = 2'd1;
  localparam logic [1:0] ADDR_BEAT_CNT = 2'd2;
  localparam logic [1:0] ADDR_CLEAR    = 2'd3;

  localparam int CTRL_ENABLE_BIT    = 0;
  localparam int CTRL_MODE_LSB      = 1;
  localparam int CTRL_MODE_MSB      = 2;
  localparam int CTRL_PROTO_ERR_BIT = 8;

  localparam int CLEAR_CNT_BIT = 0;
  localparam int CLEAR_ERR_BIT = 1;

  // Widest beat the swap helper handles; narrower buses are zero-extended into it.
  localparam int MAX_BYTES = 64;

  // Output unit k takes input unit U-1-k; bytes keep their order inside a unit.
  // Every index is a constant per byte lane once nBytes is fixed, so this is pure muxing.
  function automatic logic [MAX_BYTES*8-1:0] unit_swap(
    input logic [MAX_BYTES*8-1:0] data,
    input swap_mode_e             mode,
    input int                     nBytes
  );
    logic [MAX_BYTES*8-1:0] result;
    int src;
    result = '0;
    for (int i = 0; i < MAX_BYTES; i++) begin
      if (i < nBytes) begin
        case (mode)
          HALF:    src = nBytes - 2 - (i & ~1) + (i & 1);
          WORD:    src = nBytes - 4 - (i & ~3) + (i & 3);
          default: src = nBytes - 1 - i;
        endcase
        result[i*8 +: 8] = data[src*8 +: 8];
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/stream_skid2.sv
// Two-entry buffer (main + skid) whose ready is registered, so upstream ready
// never depends combinationally on downstream ready.
module stream_skid2
  import stream_byteswap_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_valid,
  output logic             o_ready,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  input  logic             i_ready
);

  logic             r_ready;
  logic             r_mainValid;
  logic             r_skidValid;
  logic [WIDTH-1:0] r_main;
  logic [WIDTH-1:0] r_skid;

  logic w_accept;
  logic w_mainLoad;
  logic w_skidValidNext;

  assign w_accept   = i_valid & r_ready;
  assign w_mainLoad = ~r_mainValid | i_ready;

  // A full skid always drains into main first; no accept can coincide since ready is low then.
  assign w_skidValidNext = w_mainLoad ? 1'b0 : (r_skidValid | w_accept);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ready     <= 1'b0;
      r_mainValid <= 1'b0;
      r_skidValid <= 1'b0;
      r_main      <= '0;
      r_skid      <= '0;
    end else begin
      r_ready     <= ~w_skidValidNext;
      r_skidValid <= w_skidValidNext;
      if (w_mainLoad) begin
        if (r_skidValid) begin
          r_main      <= r_skid;
          r_mainValid <= 1'b1;
        end else begin
          r_mainValid <= w_accept;
          if (w_accept) begin
            r_main <= i_data;
          end
        end
      end else if (w_accept) begin
        r_skid <= i_data;
      end
    end
  end

  assign o_ready = r_ready;
  assign o_valid = r_mainValid;
  assign o_data  = r_main;

endmodule

// File: rtl/stream_byteswap_csr.sv
// Avalon-ST unit-order swapper with per-packet shadowed config, packet/beat
// counters and a sticky protocol-error flag behind a small Avalon-MM CSR block.
module stream_byteswap_csr
  import stream_byteswap_pkg::*;
#(
  parameter int DATA_BYTES = 8,
  parameter int EMPTY_W    = $clog2(DATA_BYTES)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [DATA_BYTES*8-1:0] stream_in_data,
  input  logic [EMPTY_W-1:0]      stream_in_empty,
  input  logic                    stream_in_valid,
  input  logic                    stream_in_startofpacket,
  input  logic                    stream_in_endofpacket,
  output logic                    stream_in_ready,
  output logic [DATA_BYTES*8-1:0] stream_out_data,
  output logic [EMPTY_W-1:0]      stream_out_empty,
  output logic                    stream_out_valid,
  output logic                    stream_out_startofpacket,
  output logic                    stream_out_endofpacket,
  input  logic                    stream_out_ready,
  input  logic [1:0]              csr_address,
  input  logic                    csr_read,
  input  logic                    csr_write,
  input  logic [31:0]             csr_writedata,
  output logic [31:0]             csr_readdata,
  output logic                    csr_readdatavalid,
  output logic                    csr_waitrequest
);

  localparam int DATA_W    = DATA_BYTES * 8;
  localparam int MAX_W     = MAX_BYTES * 8;
  localparam int PAYLOAD_W = DATA_W + EMPTY_W + 2;

  logic             r_ctrlEnable;
  swap_mode_e       r_ctrlMode;
  logic             r_activeEnable;
  swap_mode_e       r_activeMode;
  logic             r_inPacket;
  logic             r_protoErr;
  logic [31:0]      r_pktCnt;
  logic [31:0]      r_beatCnt;
  logic [31:0]      r_readData;
  logic             r_readValid;

  logic             w_accept;
  logic             w_sopAccept;
  logic             w_cfgEnable;
  swap_mode_e       w_cfgMode;
  logic [DATA_W-1:0] w_swapped;
  logic [PAYLOAD_W-1:0] w_inPayload;
  logic [PAYLOAD_W-1:0] w_outPayload;
  logic             w_csrWr;
  logic             w_ctrlWr;
  logic             w_clearCnt;
  logic             w_clearErr;
  logic             w_protoViolation;
  logic [31:0]      w_readMux;

  assign w_accept    = stream_in_valid & stream_in_ready;
  assign w_sopAccept = w_accept & stream_in_startofpacket;

  // The SOP beat itself must already use the freshly shadowed config.
  assign w_cfgEnable = w_sopAccept ? r_ctrlEnable : r_activeEnable;
  assign w_cfgMode   = w_sopAccept ? r_ctrlMode   : r_activeMode;

  assign w_swapped = w_cfgEnable
                   ? DATA_W'(unit_swap(MAX_W'(stream_in_data), w_cfgMode, DATA_BYTES))
                   : stream_in_data;

  assign w_inPayload = {w_swapped, stream_in_empty, stream_in_startofpacket, stream_in_endofpacket};

  stream_skid2 #(
    .WIDTH (PAYLOAD_W)
  ) u_skid (
    .clk     (clk),
    .reset_n (reset_n),
    .i_data  (w_inPayload),
    .i_valid (stream_in_valid),
    .o_ready (stream_in_ready),
    .o_data  (w_outPayload),
    .o_valid (stream_out_valid),
    .i_ready (stream_out_ready)
  );

  assign {stream_out_data, stream_out_empty, stream_out_startofpacket, stream_out_endofpacket} = w_outPayload;

  // A simultaneous read wins over a write.
  assign w_csrWr    = csr_write & ~csr_read;
  assign w_ctrlWr   = w_csrWr & (csr_address == ADDR_CTRL);
  assign w_clearCnt = w_csrWr & (csr_address == ADDR_CLEAR) & csr_writedata[CLEAR_CNT_BIT];
  assign w_clearErr = w_csrWr & (csr_address == ADDR_CLEAR) & csr_writedata[CLEAR_ERR_BIT];

  assign w_protoViolation = w_accept & (stream_in_startofpacket ? r_inPacket : ~r_inPacket);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ctrlEnable   <= 1'b0;
      r_ctrlMode     <= BYTE;
      r_activeEnable <= 1'b0;
      r_activeMode   <= BYTE;
      r_inPacket     <= 1'b0;
    end else begin
      if (w_ctrlWr) begin
        r_ctrlEnable <= csr_writedata[CTRL_ENABLE_BIT];
        if (csr_writedata[CTRL_MODE_MSB:CTRL_MODE_LSB] != 2'b11) begin
          r_ctrlMode <= swap_mode_e'(csr_writedata[CTRL_MODE_MSB:CTRL_MODE_LSB]);
        end
      end
      if (w_sopAccept) begin
        r_activeEnable <= r_ctrlEnable;
        r_activeMode   <= r_ctrlMode;
      end
      if (w_accept) begin
        r_inPacket <= ~stream_in_endofpacket;
      end
    end
  end

  // Clears take priority over same-cycle increments or error events.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pktCnt   <= '0;
      r_beatCnt  <= '0;
      r_protoErr <= 1'b0;
    end else begin
      if (w_clearCnt) begin
        r_pktCnt  <= '0;
        r_beatCnt <= '0;
      end else begin
        if (w_sopAccept && (r_pktCnt != 32'hFFFF_FFFF)) begin
          r_pktCnt <= r_pktCnt + 32'd1;
        end
        if (w_accept && (r_beatCnt != 32'hFFFF_FFFF)) begin
          r_beatCnt <= r_beatCnt + 32'd1;
        end
      end
      if (w_clearErr) begin
        r_protoErr <= 1'b0;
      end else if (w_protoViolation) begin
        r_protoErr <= 1'b1;
      end
    end
  end

  always_comb begin
    w_readMux = '0;
    case (csr_address)
      ADDR_CTRL: begin
        w_readMux[CTRL_ENABLE_BIT]               = r_ctrlEnable;
        w_readMux[CTRL_MODE_MSB:CTRL_MODE_LSB]   = r_ctrlMode;
        w_readMux[CTRL_PROTO_ERR_BIT]            = r_protoErr;
      end
      ADDR_PKT_CNT:  w_readMux = r_pktCnt;
      ADDR_BEAT_CNT: w_readMux = r_beatCnt;
      default:       w_readMux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_readData  <= '0;
      r_readValid <= 1'b0;
    end else begin
      r_readValid <= csr_read;
      if (csr_read) begin
        r_readData <= w_readMux;
      end
    end
  end

  assign csr_readdata      = r_readData;
  assign csr_readdatavalid = r_readValid;
  assign csr_waitrequest   = ~reset_n;

endmodule

// File: tb/tb_stream_byteswap_csr.sv
// Scoreboard bench for stream_byteswap_csr: an 8-byte instance for the main
// behaviour and a 16-byte instance for the wide-bus reversal case.
module tb_stream_byteswap_csr;

  typedef struct {
    logic [127:0] data;
    logic [3:0]   empty;
    logic         sop;
    logic         eop;
  } beat_t;

  logic clk;
  logic reset_n;

  logic [63:0] inData, outData;
  logic [2:0]  inEmpty, outEmpty;
  logic inValid, inSop, inEop, inReady, outValid, outSop, outEop, outReady;
  logic [1:0]  csrAddr;
  logic        csrRead, csrWrite, csrRdv, csrWait;
  logic [31:0] csrWd, csrRd;

  logic [127:0] inData16, outData16;
  logic [3:0]   inEmpty16, outEmpty16;
  logic inValid16, inSop16, inEop16, inReady16, outValid16, outSop16, outEop16, outReady16;
  logic [1:0]  csrAddr16;
  logic        csrRead16, csrWrite16, csrRdv16, csrWait16;
  logic [31:0] csrWd16, csrRd16;

  int checks = 0;
  int errors = 0;

  beat_t q8[$];
  beat_t q16[$];
  beat_t b8, b16;

  logic        mEnable, mActEn, mInPacket, mProtoErr;
  logic [1:0]  mMode, mActMode;
  logic [31:0] mPkt, mBeat;
  logic        m16Enable, m16ActEn;
  logic [1:0]  m16Mode, m16ActMode;
  int          stallAccepts;
  int          inCount, outCount;
  logic [31:0] rd;

  stream_byteswap_csr #(.DATA_BYTES(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .stream_in_data(inData), .stream_in_empty(inEmpty), .stream_in_valid(inValid),
    .stream_in_startofpacket(inSop), .stream_in_endofpacket(inEop), .stream_in_ready(inReady),
    .stream_out_data(outData), .stream_out_empty(outEmpty), .stream_out_valid(outValid),
    .stream_out_startofpacket(outSop), .stream_out_endofpacket(outEop), .stream_out_ready(outReady),
    .csr_address(csrAddr), .csr_read(csrRead), .csr_write(csrWrite), .csr_writedata(csrWd),
    .csr_readdata(csrRd), .csr_readdatavalid(csrRdv), .csr_waitrequest(csrWait)
  );

  stream_byteswap_csr #(.DATA_BYTES(16)) dut16 (
    .clk(clk), .reset_n(reset_n),
    .stream_in_data(inData16), .stream_in_empty(inEmpty16), .stream_in_valid(inValid16),
    .stream_in_startofpacket(inSop16), .stream_in_endofpacket(inEop16), .stream_in_ready(inReady16),
    .stream_out_data(outData16), .stream_out_empty(outEmpty16), .stream_out_valid(outValid16),
    .stream_out_startofpacket(outSop16), .stream_out_endofpacket(outEop16), .stream_out_ready(outReady16),
    .csr_address(csrAddr16), .csr_read(csrRead16), .csr_write(csrWrite16), .csr_writedata(csrWd16),
    .csr_readdata(csrRd16), .csr_readdatavalid(csrRdv16), .csr_waitrequest(csrWait16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [127:0] actual, input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", tag, actual, expected);
    end
  endtask

  // Independent reference: move whole units of g bytes, unit k <- unit u-1-k.
  function automatic logic [127:0] modelSwap(input logic [127:0] d, input int nBytes,
                                             input logic en, input logic [1:0] mode);
    logic [127:0] r;
    int g, u;
    if (!en) return d;
    g = (mode == 2'd1) ? 2 : (mode == 2'd2) ? 4 : 1;
    u = nBytes / g;
    r = '0;
    for (int k = 0; k < u; k++)
      for (int b = 0; b < g; b++)
        r[(k*g+b)*8 +: 8] = d[((u-1-k)*g+b)*8 +: 8];
    return r;
  endfunction

  // Monitor/model for the 8-byte instance; sampled on the falling edge.
  always @(negedge clk) begin
    if (!reset_n) begin
      q8.delete();
      mEnable = 0; mMode = 0; mActEn = 0; mActMode = 0;
      mInPacket = 0; mProtoErr = 0; mPkt = 0; mBeat = 0;
    end else begin
      if (outValid && outReady) begin
        outCount++;
        if (q8.size() == 0) checkOutput("sb_underflow", q8.size(), 1);
        else begin
          b8 = q8.pop_front();
          checkOutput("out_data", outData, b8.data);
          checkOutput("out_side", {outEmpty, outSop, outEop}, {b8.empty[2:0], b8.sop, b8.eop});
        end
      end
      if (inValid && inReady) begin
        inCount++;
        if (!outReady) stallAccepts++;
        if (inSop) begin mActEn = mEnable; mActMode = mMode; end
        if (inSop ? mInPacket : !mInPacket) mProtoErr = 1;
        mInPacket = !inEop;
        if (mBeat != 32'hFFFF_FFFF) mBeat++;
        if (inSop && mPkt != 32'hFFFF_FFFF) mPkt++;
        q8.push_back('{modelSwap({64'h0, inData}, 8, mActEn, mActMode), {1'b0, inEmpty}, inSop, inEop});
      end
      if (csrWrite && !csrRead) begin
        if (csrAddr == 2'd0) begin
          mEnable = csrWd[0];
          if (csrWd[2:1] != 2'b11) mMode = csrWd[2:1];
        end else if (csrAddr == 2'd3) begin
          if (csrWd[0]) begin mPkt = 0; mBeat = 0; end
          if (csrWd[1]) mProtoErr = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!reset_n) begin
      q16.delete();
      m16Enable = 0; m16Mode = 0; m16ActEn = 0; m16ActMode = 0;
    end else begin
      if (outValid16 && outReady16) begin
        if (q16.size() == 0) checkOutput("sb16_underflow", q16.size(), 1);
        else begin
          b16 = q16.pop_front();
          checkOutput("out16_data", outData16, b16.data);
          checkOutput("out16_side", {outEmpty16, outSop16, outEop16}, {b16.empty, b16.sop, b16.eop});
        end
      end
      if (inValid16 && inReady16) begin
        if (inSop16) begin m16ActEn = m16Enable; m16ActMode = m16Mode; end
        q16.push_back('{modelSwap(inData16, 16, m16ActEn, m16ActMode), inEmpty16, inSop16, inEop16});
      end
      if (csrWrite16 && !csrRead16 && csrAddr16 == 2'd0) begin
        m16Enable = csrWd16[0];
        if (csrWd16[2:1] != 2'b11) m16Mode = csrWd16[2:1];
      end
    end
  end

  // All tasks start and end 1 time unit after a rising edge.
  task automatic applyStimulus(input logic [63:0] d, input logic [2:0] e, input logic s, input logic p);
    int waitCnt;
    inData = d; inEmpty = e; inSop = s; inEop = p; inValid = 1'b1;
    waitCnt = 0;
    @(negedge clk);
    while (!inReady && waitCnt < 50) begin waitCnt++; @(negedge clk); end
    if (!inReady) checkOutput("accept_timeout", inReady, 1);
    @(posedge clk); #1;
  endtask

  task automatic idle();
    inValid = 0; inSop = 0; inEop = 0;
  endtask

  task automatic sendBeat16(input logic [127:0] d, input logic [3:0] e, input logic s, input logic p);
    int waitCnt;
    inData16 = d; inEmpty16 = e; inSop16 = s; inEop16 = p; inValid16 = 1'b1;
    waitCnt = 0;
    @(negedge clk);
    while (!inReady16 && waitCnt < 50) begin waitCnt++; @(negedge clk); end
    if (!inReady16) checkOutput("accept16_timeout", inReady16, 1);
    @(posedge clk); #1;
  endtask

  task automatic csrWriteTask(input logic [1:0] a, input logic [31:0] d);
    csrAddr = a; csrWd = d; csrWrite = 1'b1;
    @(posedge clk); #1;
    csrWrite = 1'b0;
  endtask

  task automatic csrReadTask(input logic [1:0] a, output logic [31:0] data);
    csrAddr = a; csrRead = 1'b1;
    @(posedge clk); #1;
    csrRead = 1'b0;
    checkOutput("read_valid", csrRdv, 1);
    data = csrRd;
  endtask

  task automatic waitDrain();
    for (int i = 0; i < 100 && (q8.size() != 0 || q16.size() != 0); i++) @(posedge clk);
    #1;
    checkOutput("drain", q8.size() + q16.size(), 0);
  endtask

  function automatic logic [31:0] ctrlModel();
    return {23'd0, mProtoErr, 5'd0, mMode, mEnable};
  endfunction

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset_n = 0; outReady = 1; outReady16 = 1;
    inData = 0; inEmpty = 0; inValid = 0; inSop = 0; inEop = 0;
    csrAddr = 0; csrRead = 0; csrWrite = 0; csrWd = 0;
    inData16 = 0; inEmpty16 = 0; inValid16 = 0; inSop16 = 0; inEop16 = 0;
    csrAddr16 = 0; csrRead16 = 0; csrWrite16 = 0; csrWd16 = 0;
    stallAccepts = 0; inCount = 0; outCount = 0;

    #12;
    checkOutput("rst_in_ready", inReady, 0);
    checkOutput("rst_out_valid", outValid, 0);
    checkOutput("rst_waitreq", csrWait, 1);
    checkOutput("rst_rdv", csrRdv, 0);
    checkOutput("rst_rdata", csrRd, 0);
    @(posedge clk); #1 reset_n = 1;
    @(posedge clk); #1;
    checkOutput("post_rst_ready", inReady, 1);
    checkOutput("post_rst_waitreq", csrWait, 0);

    csrWriteTask(2'd0, 32'h1);
    applyStimulus(64'h0011223344556677, 3'd0, 1, 1);
    checkOutput("byte_swap", outData, 64'h7766554433221100);
    idle();
    csrReadTask(2'd1, rd);
    checkOutput("pkt_cnt_1", rd, 1);

    csrWriteTask(2'd0, 32'h3);
    applyStimulus(64'h0011223344556677, 3'd0, 1, 1);
    checkOutput("half_swap", outData, 64'h6677445522330011);
    csrWriteTask(2'd0, 32'h5);
    applyStimulus(64'h0011223344556677, 3'd0, 1, 1);
    checkOutput("word_swap", outData, 64'h4455667700112233);
    csrWriteTask(2'd0, 32'h4);
    applyStimulus(64'h0011223344556677, 3'd0, 1, 1);
    checkOutput("pass_through", outData, 64'h0011223344556677);
    idle();

    csrWriteTask(2'd0, 32'h7);
    csrReadTask(2'd0, rd);
    checkOutput("mode3_ignored", rd, 32'h5);
    csrAddr = 2'd0; csrWd = 32'h0; csrRead = 1; csrWrite = 1;
    @(posedge clk); #1;
    csrRead = 0; csrWrite = 0;
    checkOutput("rdwr_read", csrRd, 32'h5);
    csrReadTask(2'd0, rd);
    checkOutput("rdwr_write_ignored", rd, ctrlModel());

    csrWriteTask(2'd0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      if (i == 1) begin csrAddr = 2'd0; csrWd = 32'h1; csrWrite = 1; end
      applyStimulus(64'h0011223344556677 + 64'(i), 3'd0, i == 0, i == 3);
      csrWrite = 0;
      checkOutput("shadow_pass", outData, 64'h0011223344556677 + 64'(i));
      checkOutput("shadow_waitreq", csrWait, 0);
    end
    applyStimulus(64'h0011223344556677, 3'd0, 1, 0);
    checkOutput("shadow_next_swapped", outData, 64'h7766554433221100);
    applyStimulus(64'h8899AABBCCDDEEFF, 3'd3, 0, 1);
    idle();
    waitDrain();

    stallAccepts = 0;
    fork
      begin
        for (int i = 0; i < 10; i++)
          applyStimulus(64'hA000 + 64'(i), 3'd0, i == 0, i == 9);
        idle();
      end
      begin
        repeat (3) @(posedge clk);
        #1 outReady = 0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("bp_in_ready_low", inReady, 0);
        repeat (3) @(negedge clk);
        @(posedge clk); #1 outReady = 1;
      end
    join
    waitDrain();
    checkOutput("bp_skid_accepts", stallAccepts, 1);
    checkOutput("bp_in_out_count", outCount, inCount);

    applyStimulus(64'h1, 3'd0, 1, 0);
    applyStimulus(64'h2, 3'd0, 1, 0);
    applyStimulus(64'h3, 3'd0, 0, 1);
    idle();
    waitDrain();
    csrReadTask(2'd0, rd);
    checkOutput("proto_err_set", rd[8], 1);
    checkOutput("proto_ctrl", rd, ctrlModel());
    csrWriteTask(2'd3, 32'h2);
    csrReadTask(2'd0, rd);
    checkOutput("proto_err_clr", rd[8], 0);

    csrAddr = 2'd3; csrWd = 32'h1; csrWrite = 1;
    applyStimulus(64'h4, 3'd0, 1, 1);
    csrWrite = 0;
    idle();
    csrReadTask(2'd1, rd);
    checkOutput("clr_vs_sop_pkt", rd, 0);
    csrReadTask(2'd2, rd);
    checkOutput("clr_vs_sop_beat", rd, mBeat);

    outReady = 0;
    applyStimulus(64'h5, 3'd0, 1, 0);
    applyStimulus(64'h6, 3'd0, 0, 0);
    reset_n = 0;
    #1;
    checkOutput("midrst_out_valid", outValid, 0);
    checkOutput("midrst_in_ready", inReady, 0);
    checkOutput("midrst_waitreq", csrWait, 1);
    @(posedge clk); #1;
    reset_n = 1; outReady = 1; idle();
    @(posedge clk); #1;
    applyStimulus(64'h7, 3'd0, 0, 1);
    idle();
    waitDrain();
    csrReadTask(2'd0, rd);
    checkOutput("midrst_proto_err", rd, 32'h100);

    csrAddr16 = 2'd0; csrWd16 = 32'h1; csrWrite16 = 1;
    @(posedge clk); #1 csrWrite16 = 0;
    for (int i = 0; i < 3; i++) begin
      sendBeat16(128'h00112233445566778899AABBCCDDEEFF + 128'(i), (i == 2) ? 4'd5 : 4'd0, i == 0, i == 2);
      if (i == 0) checkOutput("w16_reverse", outData16, 128'hFFEEDDCCBBAA99887766554433221100);
    end
    checkOutput("w16_empty", outEmpty16, 4'd5);
    inValid16 = 0; inSop16 = 0; inEop16 = 0;
    csrAddr16 = 2'd2; csrRead16 = 1;
    @(posedge clk); #1 csrRead16 = 0;
    checkOutput("w16_beat_cnt", csrRd16, 3);
    waitDrain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stream_byteswap_csr.md
# stream_byteswap_csr

Parametrised Avalon-ST byte-order converter with a CSR block, the next generation of the team's endian swapper. It reverses the order of 1-, 2- or 4-byte units within each beat of any power-of-two bus width. It buffers the stream through a two-entry skid buffer so `stream_in_ready` never depends combinationally on `stream_out_ready`. Per-packet configuration is shadowed at start-of-packet, so CSR writes never stall and never corrupt a packet in flight.

## Interface
- `DATA_BYTES`, 8, beat width in bytes; power of two, ≥4
- `EMPTY_W`, `$clog2(DATA_BYTES)`, empty field width (derived, not overridden)
- `clk`  in  1  clock
- `reset_n`  in  1  reset, asynchronous, active-low
- `stream_in_data`  in  `DATA_BYTES*8`  input beat
- `stream_in_empty`  in  `EMPTY_W`  unused bytes on EOP beat
- `stream_in_valid`, `stream_in_startofpacket`, `stream_in_endofpacket`  in  1 each  Avalon-ST sideband
- `stream_in_ready`  out  1  sink ready, readyLatency 0
- `stream_out_data`, `stream_out_empty`, `stream_out_valid`, `stream_out_startofpacket`, `stream_out_endofpacket`  out  as input  source side
- `stream_out_ready`  in  1  downstream ready
- `csr_address`  in  2  register select
- `csr_read`, `csr_write`  in  1  Avalon-MM strobes
- `csr_writedata`  in  32  write data
- `csr_readdata`  out  32  read data
- `csr_readdatavalid`  out  1  read data valid; fixed read latency 1
- `csr_waitrequest`  out  1  asserted only while `reset_n` is low

## Operation
- CSR map:
  - 0 CTRL: bit0 enable (R/W); bits2:1 mode (R/W): 0 = byte, 1 = 16-bit, 2 = 32-bit, a write of 3 leaves mode unchanged; bit8 proto_err (RO, sticky).
  - 1 PKT_CNT (RO).
  - 2 BEAT_CNT (RO).
  - 3 CLEAR (WO): bit0 clears both counters; bit1 clears proto_err. Reads of address 3 return 0.
- Shadowing: {enable, mode} is copied into the active config on every accepted SOP beat. All beats of that packet use the active config. CTRL writes never affect the packet in flight.
- Swap with unit size G = 1/2/4 bytes and U = DATA_BYTES/G units: output unit k = input unit U-1-k; byte order inside a unit is preserved. Disabled means pass-through. `empty`, SOP and EOP pass through unchanged.
- Accepted beat = `stream_in_valid & stream_in_ready`.
- PKT_CNT increments on each accepted SOP; BEAT_CNT increments on each accepted beat. Both are 32-bit and saturate at 0xFFFFFFFF.
- A clear on the same cycle as an increment gives 0.
- proto_err sets on either of:
  - an accepted SOP while in a packet;
  - an accepted non-SOP beat while idle.
  The beat is still forwarded. An accepted SOP+EOP beat is a complete single-beat packet.
- Sub-block `stream_skid2`: two-entry buffer (main register plus skid register). The swap is applied before the skid, so both entries hold already-swapped data.

## Timing
- Reset values:
  - stream side: `stream_out_valid`=0, `stream_in_ready`=0 during reset then 1; data/empty/SOP/EOP=0;
  - CSR side: `csr_readdatavalid`=0, `csr_readdata`=0, `csr_waitrequest`=1 while reset is asserted;
  - internal: CTRL=0, counters=0, active config=0, in_packet=0, skid empty.
- Latency: an accepted beat appears on `stream_out_*` the next cycle.
- `stream_in_ready` is registered and equals "skid entry empty".
- Sustained throughput is 1 beat/cycle while `stream_out_ready`=1.
- Once `stream_out_valid` is asserted, output data and sideband hold until `stream_out_ready` is sampled high.
- On backpressure: at most one more beat is accepted into the skid, then `stream_in_ready` drops on the following cycle. It returns 1 the cycle after the skid drains.
- CSR reads: `csr_readdata`/`csr_readdatavalid` update 1 cycle after `csr_read`. A read issued on the same cycle as an increment returns the pre-increment value.
- If `csr_read` and `csr_write` are both high, the read is performed and the write is ignored.
- Asserting reset mid-packet discards buffered beats immediately. The next accepted beat must be an SOP, otherwise proto_err sets.

## Structure
- Package `stream_byteswap_pkg` holds:
  - `swap_mode_e` (BYTE, HALF, WORD);
  - CSR address constants `ADDR_CTRL`, `ADDR_PKT_CNT`, `ADDR_BEAT_CNT`, `ADDR_CLEAR`;
  - CTRL bit-position constants;
  - function `unit_swap(data, mode)`, written as a generate-friendly loop over units.
- One sub-module: `stream_skid2`, parametrised on payload width (data + empty + SOP + EOP).

## Test plan
- Mode BYTE, enable=1, DATA_BYTES=8, input 0x0011223344556677 -> output 0x7766554433221100; PKT_CNT=1.
- Mode HALF, input 0x0011223344556677 -> 0x6677445522330011; mode WORD -> 0x4455667700112233; enable=0 -> unchanged.
- CTRL write of enable=1 on beat 2 of a 4-beat packet -> all 4 beats pass through; the next packet is swapped; `csr_waitrequest` stays 0.
- `stream_out_ready` held low 5 cycles during a 10-beat stream -> exactly 2 beats are buffered, none lost or duplicated, output order preserved, `stream_in_ready` low on the cycle after the second buffered beat.
- SOP, then SOP with no EOP between -> proto_err=1; write CLEAR bit1 -> proto_err=0. CLEAR bit0 on the same cycle as an accepted SOP -> PKT_CNT reads 0.
- DATA_BYTES=16 instance, BYTE mode, 3-beat packet with empty=5 on EOP -> full-beat reversal, empty=5 passed through, BEAT_CNT=3.
